// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the responder state encoding, word geometry and the wait-counter width,
// plus a helper that decides whether a word index fits the array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int WORD_BYTES = 4;
  localparam int WAIT_CNT_W = 4;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;

  // True when any word-index bit at or above idx_w is set, i.e. the word
  // lies beyond an array of 2**idx_w words.
  function automatic logic idx_out_of_range(input logic [ADDR_W-3:0] word_idx,
                                            input int               idx_w);
    logic hit;
    hit = 1'b0;
    for (int b = 0; b < ADDR_W - 2; b++) begin
      if ((b >= idx_w) && word_idx[b]) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM for the data-memory responder.
// One access per cycle: either a write (we_i) or a registered read (re_i).
// The read register can be cleared (clr_i) so an error response shows zero,
// and it holds its value otherwise. Array contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  localparam int IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic              re_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Array write port; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Registered read data: reset/clear to zero, load on read, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (clr_i) begin
      rdata_q <= {DATA_W{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[idx_i];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the processor data-memory interface.
// Accepts one read or write request, waits WAIT_STATES cycles, then responds
// with a one-cycle ready pulse (and err for malformed requests).
// Optional feature: define DMEM_ALIGN_CHECK_EN to reject addresses with
// addr[1:0] != 0; otherwise the low two address bits are ignored.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              err,
  output logic              busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? {WAIT_CNT_W{1'b0}} : WAIT_CNT_W'(WAIT_STATES - 1);

  state_e              state_q,     state_d;
  logic [WAIT_CNT_W-1:0] cnt_q,     cnt_d;
  logic                req_rd_q,    req_rd_d;
  logic                req_wr_q,    req_wr_d;
  logic [ADDR_W-1:0]   req_addr_q,  req_addr_d;
  logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
  logic                ready_q,     ready_d;
  logic                err_q,       err_d;
  logic                busy_q,      busy_d;

  logic                enter_resp_s;
  logic                resp_err_s;
  logic                misalign_s;
  logic                arr_we_s;
  logic                arr_re_s;
  logic                arr_clr_s;
  logic [IDX_W-1:0]    arr_idx_s;
  logic [DATA_W-1:0]   arr_rdata_s;
  logic                unused_addr_lsb_s;

  // Low address bits only matter when the alignment check is compiled in.
  assign unused_addr_lsb_s = ^req_addr_q[1:0];

  // State, wait counter and latched request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {WAIT_CNT_W{1'b0}};
      req_rd_q    <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= {ADDR_W{1'b0}};
      req_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_rd_q    <= req_rd_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, one cycle of RESP.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_rd_d    = req_rd_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          req_rd_d    = mem_read;
          req_wr_d    = mem_write;
          req_addr_d  = addr;
          req_wdata_d = wdata;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
            cnt_d   = {WAIT_CNT_W{1'b0}};
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == {WAIT_CNT_W{1'b0}}) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {WAIT_CNT_W{1'b0}};
      end
    endcase
  end

  // Output and array-control decode. The request copy used here is the one
  // being latched this edge, so a zero-wait access reads on acceptance.
  always_comb begin
    enter_resp_s = (state_d == RESP) && (state_q != RESP);
`ifdef DMEM_ALIGN_CHECK_EN
    misalign_s = (req_addr_d[1:0] != 2'b00);
`else
    misalign_s = 1'b0;
`endif
    resp_err_s = (req_rd_d && req_wr_d)
               || idx_out_of_range(req_addr_d[ADDR_W-1:2], IDX_W)
               || misalign_s;
    ready_d   = enter_resp_s;
    err_d     = enter_resp_s && resp_err_s;
    busy_d    = (state_d != IDLE);
    arr_re_s  = enter_resp_s && req_rd_d && !resp_err_s;
    arr_clr_s = enter_resp_s && resp_err_s;
    // Write lands at the end of RESP; a reset in that cycle drops it.
    arr_we_s  = (state_q == RESP) && req_wr_q && !err_q && !rst;
    if (arr_we_s) begin
      arr_idx_s = req_addr_q[IDX_W+1:2];
    end else begin
      arr_idx_s = req_addr_d[IDX_W+1:2];
    end
  end

  // Registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (arr_we_s),
    .re_i    (arr_re_s),
    .clr_i   (arr_clr_s),
    .idx_i   (arr_idx_s),
    .wdata_i (req_wdata_q),
    .rdata_o (arr_rdata_s)
  );

  assign rdata = arr_rdata_s;
  assign ready = ready_q;
  assign err   = err_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: one instance with two wait
// states and one with none, driven by per-scenario tasks and checked against
// a scoreboard of expected responses built from a small reference model.
module tb_data_mem_responder;

  localparam int WS_A  = 2;
  localparam int WS_B  = 0;
  localparam int DEPTH = 256;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_s    [2];
  logic        wr_s    [2];
  logic [31:0] addr_s  [2];
  logic [31:0] wdata_s [2];
  logic [31:0] rdata_s [2];
  logic        ready_s [2];
  logic        err_s   [2];
  logic        busy_s  [2];

  exp_t        sb_q[$];
  logic [31:0] mdl0 [int];
  logic [31:0] mdl1 [int];
  logic [31:0] last_rdata [2];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_A)) dut_a (
    .clk(clk), .rst(rst), .mem_read(rd_s[0]), .mem_write(wr_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .ready(ready_s[0]), .err(err_s[0]), .busy(busy_s[0]));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS_B)) dut_b (
    .clk(clk), .rst(rst), .mem_read(rd_s[1]), .mem_write(wr_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .ready(ready_s[1]), .err(err_s[1]), .busy(busy_s[1]));

  function automatic logic [31:0] mdl_read(input int sel, input int idx);
    if (sel == 0) return mdl0.exists(idx) ? mdl0[idx] : 32'hxxxx_xxxx;
    else          return mdl1.exists(idx) ? mdl1[idx] : 32'hxxxx_xxxx;
  endfunction

  // One request through the scoreboard: expectation pushed when driven,
  // popped and compared when ready arrives (or the cycle budget runs out).
  task automatic do_req(input int sel, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input string name);
    exp_t e;
    logic bad;
    int   idx;
    int   cyc;
    bit   seen;
    idx = int'(a[31:2]);
    bad = (rd && wr) || (a[31:2] >= 30'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
    bad = bad || (a[1:0] != 2'b00);
`endif
    e.err = bad;
    e.lat = ((sel == 0) ? WS_A : WS_B) + 1;
    if (bad)     e.rdata = 32'h0000_0000;
    else if (rd) e.rdata = mdl_read(sel, idx);
    else         e.rdata = last_rdata[sel];
    if (!bad && wr) begin
      if (sel == 0) mdl0[idx] = d; else mdl1[idx] = d;
    end
    last_rdata[sel] = e.rdata;
    sb_q.push_back(e);

    @(negedge clk);
    rd_s[sel] = rd; wr_s[sel] = wr; addr_s[sel] = a; wdata_s[sel] = d;
    @(posedge clk);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        tests_run++;
        if (busy_s[sel] !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s busy: got %b want 1", name, busy_s[sel]);
        end
      end
      if (ready_s[sel] === 1'b1) seen = 1'b1;
    end
    rd_s[sel] = 1'b0; wr_s[sel] = 1'b0;
    e = sb_q.pop_front();
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s timeout: no ready within %0d cycles", name, cyc);
    end else begin
      if (cyc != e.lat) begin
        tests_failed++;
        $display("FAIL %s latency: got %0d want %0d", name, cyc, e.lat);
      end
      tests_run++;
      if (err_s[sel] !== e.err) begin
        tests_failed++;
        $display("FAIL %s err: got %b want %b", name, err_s[sel], e.err);
      end
      tests_run++;
      if (rdata_s[sel] !== e.rdata) begin
        tests_failed++;
        $display("FAIL %s rdata: got %h want %h", name, rdata_s[sel], e.rdata);
      end
    end
    @(negedge clk);
    tests_run++;
    if (ready_s[sel] !== 1'b0 || busy_s[sel] !== 1'b0 || err_s[sel] !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after: ready=%b busy=%b err=%b want 0/0/0",
               name, ready_s[sel], busy_s[sel], err_s[sel]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rd_s[s] = 1'b0; wr_s[s] = 1'b0; addr_s[s] = 32'h0; wdata_s[s] = 32'h0;
      last_rdata[s] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        tests_run++;
        if (rdata_s[s] !== 32'h0 || ready_s[s] !== 1'b0 ||
            err_s[s] !== 1'b0 || busy_s[s] !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_idle dut%0d cyc%0d: rdata=%h ready=%b err=%b busy=%b want 0",
                   s, c, rdata_s[s], ready_s[s], err_s[s], busy_s[s]);
        end
      end
    end
  endtask

  task automatic test_write_read();
    do_req(0, 1'b0, 1'b1, 32'h0000_0000, 32'h0BAD_F00D, "wr_0x0");
    do_req(0, 1'b0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, "wr_0x40");
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, "rd_0x40");
  endtask

  task automatic test_zero_wait();
    do_req(1, 1'b0, 1'b1, 32'h0000_0000, 32'h1234_5678, "zw_wr_0x0");
    do_req(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, "zw_rd_0x0");
  endtask

  task automatic test_out_of_range();
    do_req(0, 1'b0, 1'b1, 32'h0000_03FC, 32'hCAFE_0001, "wr_last_word");
    do_req(0, 1'b1, 1'b0, 32'h0000_03FC, 32'h0000_0000, "rd_last_word");
    do_req(0, 1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, "wr_oor");
    do_req(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, "rd_0x0_after_oor");
    do_req(0, 1'b1, 1'b0, 32'h8000_0040, 32'h0000_0000, "rd_high_bit");
    do_req(1, 1'b0, 1'b1, 32'h0001_0000, 32'h5555_AAAA, "zw_wr_oor");
    do_req(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, "zw_rd_after_oor");
  endtask

  task automatic test_both_misalign();
    do_req(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0000, "both_strobes");
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000, "rd_0x40_intact");
    do_req(0, 1'b1, 1'b0, 32'h0000_0042, 32'h0000_0000, "rd_0x42");
    do_req(1, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, "zw_both_strobes");
  endtask

  task automatic test_reset_mid_write();
    bit got_ready;
    do_req(0, 1'b0, 1'b1, 32'h0000_0080, 32'h1111_2222, "wr_0x80_old");
    @(negedge clk);
    rd_s[0] = 1'b0; wr_s[0] = 1'b1; addr_s[0] = 32'h0000_0080; wdata_s[0] = 32'hA5A5_A5A5;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    wr_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    last_rdata[0] = 32'h0;
    last_rdata[1] = 32'h0;
    got_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ready_s[0] === 1'b1 || busy_s[0] === 1'b1) got_ready = 1'b1;
    end
    tests_run++;
    if (got_ready) begin
      tests_failed++;
      $display("FAIL reset_abort: got ready/busy after reset want none");
    end
    do_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_0000, "rd_0x80_after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      do_req(0, 1'b0, 1'b1, 32'h0000_0100 + 32'(i * 4), v, "b2b_wr");
      do_req(0, 1'b1, 1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, "b2b_rd");
      do_req(1, 1'b0, 1'b1, 32'h0000_0200 + 32'(i * 4), ~v, "b2b_zw_wr");
      do_req(1, 1'b1, 1'b0, 32'h0000_0200 + 32'(i * 4), 32'h0, "b2b_zw_rd");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_out_of_range();
    test_both_misalign();
    test_reset_mid_write();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory interface. Accepts single-word read and write requests from the datapath's load/store/push/pop/call paths. Services them from an internal word array after a configurable number of wait states. Returns read data and a one-cycle `ready` completion pulse. Flags malformed requests with `err` and never modifies memory for them.

## Interface
- `DEPTH_WORDS`, 256 — number of 32-bit words in the array; power of two, minimum 4.
- `WAIT_STATES`, 2 — idle cycles inserted between request acceptance and response; range 0–15.
- `clk` input 1 — single clock; all state updates on the rising edge.
- `rst` input 1 — synchronous, active-high reset.
- `mem_read` input 1 — read request; held by the initiator until `ready`.
- `mem_write` input 1 — write request; held by the initiator until `ready`.
- `addr` input 32 — byte address; word index is `addr[31:2]`.
- `wdata` input 32 — write data, sampled at acceptance.
- `rdata` output 32 — registered read data.
- `ready` output 1 — one-cycle completion pulse.
- `err` output 1 — one-cycle error flag, coincident with `ready`.
- `busy` output 1 — high from acceptance through the `ready` cycle inclusive.

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: a request is accepted when `mem_read | mem_write` is high. `addr`, `wdata`, and the operation are latched into request registers.
  - If `WAIT_STATES` = 0, the next state is RESP.
  - Otherwise the next state is WAIT, with the wait counter loaded to `WAIT_STATES-1`.
- WAIT: the counter decrements each cycle. When the counter is 0, the next state is RESP.
- RESP: `ready` = 1 for exactly one cycle, then the next state is IDLE. No request is accepted in the RESP cycle itself.
- Error conditions, evaluated on the latched request:
  - both `mem_read` and `mem_write` high at acceptance;
  - word index ≥ `DEPTH_WORDS`, where every bit of `addr[31:2]` above the index width must be zero;
  - misalignment, only when the alignment check is compiled in (see Configuration).
- Any error: `err` = 1 in the RESP cycle, no write, `rdata` forced to 0.
- Valid write: the array is written in the RESP cycle. `rdata` is unchanged.
- Valid read: `rdata` is loaded with the array word so that it is valid in the RESP cycle. `rdata` holds that value until the next read or error response.
- Requests that change or drop mid-transaction are ignored; the latched copy is authoritative.
- Reset values: `rdata` = 0, `ready` = 0, `err` = 0, `busy` = 0, state IDLE, counter 0.
- Reset mid-transaction aborts the transaction; a pending write is dropped. Array contents are not cleared by reset.

## Timing
- Latency from the acceptance edge to `ready` high is `WAIT_STATES+1` cycles. Example: `WAIT_STATES` = 2 means acceptance at cycle n and `ready` at cycle n+3.
- Throughput: one request per `WAIT_STATES+2` cycles.
- If the initiator keeps a request asserted in the cycle after `ready`, that is treated as a new request; the initiator must deassert.
- A write immediately followed by a read of the same address returns the new data.
- The array read port is synchronous, with one cycle of array latency absorbed inside the WAIT/RESP sequencing.
- With `WAIT_STATES` = 0, the array is read on the acceptance edge.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined: `addr[1:0]` ≠ 0 produces an `err` response with no access.
- `DMEM_ALIGN_CHECK_EN` undefined: `addr[1:0]` is ignored, and the access targets word `addr[31:2]`.

## Structure
- Package `dmem_pkg` holds:
  - the state enum (IDLE/WAIT/RESP);
  - `WORD_BYTES` = 4;
  - `WAIT_CNT_W` = 4.
- Sub-module `dmem_array`: single-port synchronous RAM, parameterised by `DEPTH_WORDS`, with write-enable, index, write data and registered read data.
- The FSM, counter and error decode live in `data_mem_responder`.

## Test plan
- **Reset then idle:** assert `rst` for 2 cycles. Then `rdata` = 0, `ready` = 0, `err` = 0, `busy` = 0, with no activity for 10 cycles.
- **Write then read back (`WAIT_STATES` = 2):** write `0xDEADBEEF` to `0x40`; `ready` at acceptance+3 with `err` = 0. Then read `0x40`; `rdata` = `0xDEADBEEF` with `ready` at acceptance+3.
- **Zero wait states:** with `WAIT_STATES` = 0, write `0x12345678` to `0x0` and read it back. Each `ready` arrives 1 cycle after acceptance.
- **Out-of-range write:** write to `0x400` with `DEPTH_WORDS` = 256. Response is `ready` = 1, `err` = 1, `rdata` = 0. A subsequent read of `0x0` returns its prior value.
- **Both strobes / misalignment:** `mem_read` and `mem_write` both high gives `err` = 1. A read of `0x42` gives `err` = 1 when `DMEM_ALIGN_CHECK_EN` is defined; when it is undefined, the read returns word `0x40`.
- **Reset mid-write:** pulse `rst` during WAIT of a write of `0xA5A5A5A5` to `0x80`. No `ready` follows, and a later read of `0x80` returns the old value.
